sigma_delta_sample_feeder: RTL and testbench
============================================

// Module: sigma_delta_sample_feeder
// PURPOSE
//   Upstream stage of the sigma-delta modulator core. Accepts samples over a
//   valid/ready stream into a small FIFO. Presents each sample on value/enable,
//   holding it for exactly OSR clock cycles (zero-order-hold oversampling).
//   Repeats the last sample and flags underrun when the FIFO runs dry.
// PARAMETERS
//   VALUE_WIDTH  8   sample width; matches the modulator core input width
//   OSR_WIDTH    16  width of the oversampling-ratio input
//   FIFO_DEPTH   4   sample FIFO entries; power of 2, >= 2
// PORTS
//   clk           in   1                   clock
//   resetn        in   1                   async reset, active low
//   s_data        in   VALUE_WIDTH         input sample
//   s_valid       in   1                   s_data valid
//   s_ready       out  1                   FIFO can accept (= !full)
//   run           in   1                   start/continue modulation
//   osr           in   OSR_WIDTH           cycles per sample; 0 treated as 1
//   clr_underrun  in   1                   clears sticky underrun flag
//   value         out  VALUE_WIDTH         sample to modulator core
//   enable        out  1                   modulator enable
//   sample_tick   out  1                   1-cycle pulse: new FIFO sample loaded
//   underrun      out  1                   sticky: period boundary with empty FIFO
//   level         out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   Reset (async, resetn=0): FIFO empty, level=0, s_ready=1, state IDLE, value=0,
//     enable=0, sample_tick=0, underrun=0, period counter=0. All outputs registered.
//   FIFO: push on s_valid&&s_ready. s_ready=!full. A pop in the same cycle does not
//     free space for a push. Pop only at the load points defined below.
//   osr_eff = (osr==0) ? 1 : osr. Sampled at every load point and held for the period.
//   IDLE: enable=0, value=0. If run=1 and FIFO non-empty at edge:
//     pop -> value; cnt<=osr_eff-1; enable<=1; sample_tick<=1; -> RUN.
//   RUN: cnt decrements each cycle. Each value is held exactly osr_eff cycles with enable=1.
//     At cnt==0 edge (period boundary), first matching rule applies:
//       run=0            -> IDLE; enable<=0, value<=0 next cycle. FIFO contents retained.
//       FIFO non-empty   -> pop into value; reload cnt; sample_tick<=1.
//       FIFO empty       -> value unchanged; reload cnt; underrun<=1; no sample_tick.
//     A run drop mid-period does not cut the period short.
//   A sample pushed in the same cycle as a boundary with an empty FIFO is not visible
//     until the next boundary.
//   underrun: set as above. Cleared by clr_underrun=1 or a run rising edge in IDLE.
//     Set has priority over clear in the same cycle.
//   level: +1 on push, -1 on pop, unchanged when both occur.
//     Pointers wrap modulo FIFO_DEPTH.
//   osr changes mid-period take effect only at the next load point.
// TESTING
//   1. osr=4, run=1, push 0x10,0x20,0x30 -> value 0x10/0x20/0x30 each 4 cycles,
//      enable=1, sample_tick every 4th cycle, underrun stays 0 until 4th boundary.
//   2. run=0, push 5 samples back-to-back -> 4 accepted, s_ready=0 after 4th, level=4,
//      5th held on s_data/s_valid until run=1 pops; accepted 1 cycle after the pop.
//   3. osr=3, one sample 0x7F then none -> 0x7F held 6+ cycles, underrun=1 at cycle 3,
//      no second sample_tick; push 0x01 -> loaded at next boundary with sample_tick.
//   4. osr=8, run dropped at cycle 2 of a period -> enable stays 1 through cycle 7,
//      then enable=0, value=0. Remaining FIFO samples intact (level unchanged).
//   5. osr=0 with 3 queued samples -> new value every cycle, 3 consecutive sample_ticks.
//   6. resetn pulsed low mid-RUN with level=2 -> immediately enable=0, value=0,
//      level=0, s_ready=1, underrun=0. Resumes only after a new push with run=1.

Source files
------------

// File: rtl/sigma_delta_sample_feeder_if.sv
// sigma_delta_sample_feeder_if: valid/ready sample stream into the feeder FIFO
interface sigma_delta_sample_feeder_if #(
    parameter int VALUE_WIDTH = 8
);
    logic [VALUE_WIDTH-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sigma_delta_sample_feeder.sv
// sigma_delta_sample_feeder: FIFO-buffered zero-order-hold sample feeder for the modulator core
module sigma_delta_sample_feeder #(
    parameter int VALUE_WIDTH = 8,
    parameter int OSR_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    sigma_delta_sample_feeder_if.slave    s,
    input  logic                          run,
    input  logic [OSR_WIDTH-1:0]          osr,
    input  logic                          clr_underrun,
    output logic [VALUE_WIDTH-1:0]        value,
    output logic                          enable,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    logic [VALUE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic                   r_ready;
    state_t                 r_state;
    logic [OSR_WIDTH-1:0]   r_cnt;
    logic [VALUE_WIDTH-1:0] r_value;
    logic                   r_enable;
    logic                   r_tick;
    logic                   r_underrun;
    logic                   r_run_d;

    state_t                 w_state_nx;
    logic [OSR_WIDTH-1:0]   w_cnt_nx;
    logic [VALUE_WIDTH-1:0] w_value_nx;
    logic                   w_enable_nx;
    logic                   w_tick_nx;
    logic                   w_pop;
    logic                   w_und_set;
    logic                   w_und_clr;
    logic                   w_push;
    logic                   w_empty;
    logic [LW-1:0]          w_level_nx;
    logic [OSR_WIDTH-1:0]   w_reload;

    assign w_push      = s.s_valid && r_ready;
    assign w_empty     = (r_level == '0);
    assign w_reload    = (osr == '0) ? '0 : osr - 1'b1;
    assign w_level_nx  = (w_push && !w_pop) ? r_level + 1'b1 :
                         (w_pop && !w_push) ? r_level - 1'b1 : r_level;
    assign w_und_clr   = clr_underrun || (r_state == IDLE && run && !r_run_d);

    assign s.s_ready   = r_ready;
    assign value       = r_value;
    assign enable      = r_enable;
    assign sample_tick = r_tick;
    assign underrun    = r_underrun;
    assign level       = r_level;

    // sample storage; contents need no reset since pointers/level define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s.s_data;
    end

    // FIFO pointers, occupancy and registered ready (ready reflects occupancy after this edge)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_level  <= w_level_nx;
            r_ready  <= (w_level_nx != LW'(FIFO_DEPTH));
        end
    end

    // next-state: load on IDLE start or at a period boundary, otherwise count down the hold
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_value_nx  = r_value;
        w_enable_nx = r_enable;
        w_tick_nx   = 1'b0;
        w_pop       = 1'b0;
        w_und_set   = 1'b0;
        if (r_state == IDLE) begin
            w_enable_nx = 1'b0;
            w_value_nx  = '0;
            if (run && !w_empty) begin
                w_pop       = 1'b1;
                w_value_nx  = r_mem[r_rd_ptr];
                w_cnt_nx    = w_reload;
                w_enable_nx = 1'b1;
                w_tick_nx   = 1'b1;
                w_state_nx  = RUN;
            end
        end else if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - 1'b1;
        end else if (!run) begin
            w_state_nx  = IDLE;
            w_enable_nx = 1'b0;
            w_value_nx  = '0;
        end else begin
            w_cnt_nx = w_reload;
            if (!w_empty) begin
                w_pop      = 1'b1;
                w_value_nx = r_mem[r_rd_ptr];
                w_tick_nx  = 1'b1;
            end else begin
                w_und_set = 1'b1;
            end
        end
    end

    // state and output registers; underrun set wins over clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_value    <= '0;
            r_enable   <= 1'b0;
            r_tick     <= 1'b0;
            r_underrun <= 1'b0;
            r_run_d    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_value    <= w_value_nx;
            r_enable   <= w_enable_nx;
            r_tick     <= w_tick_nx;
            r_underrun <= w_und_set ? 1'b1 : (w_und_clr ? 1'b0 : r_underrun);
            r_run_d    <= run;
        end
    end
endmodule

// File: tb/tb_sigma_delta_sample_feeder.sv
// tb_sigma_delta_sample_feeder: directed checks of load timing, hold, underrun, backpressure and reset
module tb_sigma_delta_sample_feeder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [15:0] osr = 16'd4;
    logic        clr_underrun = 1'b0;
    logic [7:0]  value;
    logic        enable;
    logic        sample_tick;
    logic        underrun;
    logic [2:0]  level;
    int          n_tests = 0;
    int          n_fail = 0;

    sigma_delta_sample_feeder_if #(.VALUE_WIDTH(8)) sif ();

    sigma_delta_sample_feeder dut (
        .clk(clk), .resetn(resetn), .s(sif.slave), .run(run), .osr(osr),
        .clr_underrun(clr_underrun), .value(value), .enable(enable),
        .sample_tick(sample_tick), .underrun(underrun), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input logic [7:0] d);
        sif.s_data = d;
        sif.s_valid = 1'b1;
        tick();
        sif.s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] s1 [3];
        logic [7:0] s5 [4];
        s1 = '{8'h10, 8'h20, 8'h30};
        s5 = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        sif.s_data = '0;
        sif.s_valid = 1'b0;
        tick();
        tick();
        check("rst_enable", enable, 0);
        check("rst_value", value, 0);
        check("rst_level", level, 0);
        check("rst_ready", sif.s_ready, 1);
        check("rst_underrun", underrun, 0);
        check("rst_tick", sample_tick, 0);
        resetn = 1'b1;
        tick();

        // osr=4, three samples each held 4 cycles, underrun at the 4th boundary
        osr = 16'd4;
        for (int i = 0; i < 3; i++) push_idle(s1[i]);
        check("t1_level", level, 3);
        run = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            tick();
            check($sformatf("t1_value_%0d", t), value, (t < 12) ? s1[t/4] : 8'h30);
            check($sformatf("t1_tick_%0d", t), sample_tick, (t < 12 && t % 4 == 0) ? 1 : 0);
            check($sformatf("t1_en_%0d", t), enable, 1);
            check($sformatf("t1_und_%0d", t), underrun, (t == 12) ? 1 : 0);
        end
        run = 1'b0;
        for (int t = 13; t <= 16; t++) tick();
        check("t1_stop_en", enable, 0);
        check("t1_stop_val", value, 0);
        check("t1_und_sticky", underrun, 1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("t1_und_clr", underrun, 0);

        // backpressure: 4 accepted, 5th waits for a pop; then osr=8 with mid-period run drop
        osr = 16'd8;
        sif.s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sif.s_data = 8'hA1 + 8'(i);
            tick();
        end
        check("t2_level4", level, 4);
        check("t2_ready0", sif.s_ready, 0);
        sif.s_data = 8'hA5;
        tick();
        tick();
        check("t2_level_hold", level, 4);
        run = 1'b1;
        tick();
        check("t2_pop_level", level, 3);
        check("t2_pop_ready", sif.s_ready, 1);
        check("t2_pop_value", value, 8'hA1);
        check("t2_pop_tick", sample_tick, 1);
        tick();
        sif.s_valid = 1'b0;
        check("t2_accept5", level, 4);
        run = 1'b0;
        for (int t = 2; t <= 8; t++) begin
            tick();
            check($sformatf("t4_en_%0d", t), enable, (t < 8) ? 1 : 0);
            check($sformatf("t4_val_%0d", t), value, (t < 8) ? 8'hA1 : 8'h00);
        end
        check("t4_level_kept", level, 4);

        // osr=0 behaves as 1: a new sample every cycle, then underrun
        osr = 16'd0;
        run = 1'b1;
        for (int u = 0; u <= 4; u++) begin
            tick();
            check($sformatf("t5_val_%0d", u), value, (u < 4) ? s5[u] : 8'hA5);
            check($sformatf("t5_tick_%0d", u), sample_tick, (u < 4) ? 1 : 0);
            check($sformatf("t5_und_%0d", u), underrun, (u == 4) ? 1 : 0);
        end
        run = 1'b0;
        tick();
        check("t5_idle_en", enable, 0);
        check("t5_und_sticky", underrun, 1);

        // osr=3, single sample starves; push on the empty boundary appears one period later
        osr = 16'd3;
        push_idle(8'h7F);
        run = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            sif.s_valid = (t == 3);
            sif.s_data = 8'h01;
            tick();
            check($sformatf("t3_val_%0d", t), value, (t < 6) ? 8'h7F : 8'h01);
            check($sformatf("t3_tick_%0d", t), sample_tick, (t == 0 || t == 6) ? 1 : 0);
            check($sformatf("t3_und_%0d", t), underrun, (t >= 3) ? 1 : 0);
            check($sformatf("t3_lvl_%0d", t), level, (t >= 3 && t < 6) ? 1 : 0);
        end
        sif.s_valid = 1'b0;

        // async reset mid-RUN with two queued samples
        sif.s_valid = 1'b1;
        sif.s_data = 8'h55;
        tick();
        sif.s_data = 8'h66;
        tick();
        sif.s_valid = 1'b0;
        check("t6_level2", level, 2);
        resetn = 1'b0;
        #1;
        check("t6_en", enable, 0);
        check("t6_val", value, 0);
        check("t6_level", level, 0);
        check("t6_ready", sif.s_ready, 1);
        check("t6_und", underrun, 0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        tick();
        check("t6_stay_idle", enable, 0);
        push_idle(8'h99);
        tick();
        check("t6_resume_val", value, 8'h99);
        check("t6_resume_en", enable, 1);
        check("t6_resume_tick", sample_tick, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
